// File: rtl/osd_pkg.sv
// Shared constants and types for the digit overlay OSD: glyph geometry,
// default colours, and the coordinate and bounding-box types.
package osd_pkg;
    localparam int GLYPH_W     = 5;
    localparam int GLYPH_H     = 7;
    localparam int GLYPH_SCALE = 2;

    localparam logic [7:0]  NO_DIGIT  = 8'hFF;
    localparam logic [7:0]  MAX_DIGIT = 8'd9;

    localparam logic [23:0] DEF_BOX_COLOR   = 24'hFF0000;
    localparam logic [23:0] DEF_GLYPH_COLOR = 24'h00FF00;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    localparam coord_t COORD_MAX = '1;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
        logic   valid;
    } box_t;

    // Increment that sticks at the top of the coordinate range.
    function automatic coord_t sat_inc(input coord_t v);
        return (v == COORD_MAX) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/digit_font_rom.sv
// 5x7 digit font with a registered output. The address is {digit, row};
// row 7 and any digit code above 9 read back as blank.
module digit_font_rom
    import osd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         addr,
    output logic [GLYPH_W-1:0] data
);
    logic [GLYPH_W*GLYPH_H-1:0] glyph;
    logic [GLYPH_W-1:0]         row_bits;

    // Rows are packed top row first; bit 4 of each row is the leftmost pixel.
    always_comb begin
        case (addr[6:3])
            4'd0:    glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            4'd1:    glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2:    glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            4'd3:    glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd4:    glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5:    glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6:    glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7:    glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: glyph = '0;
        endcase
        row_bits = '0;
        if (addr[2:0] != 3'd7)
            row_bits = GLYPH_W'(glyph >> (GLYPH_W * (GLYPH_H - 1 - int'(addr[2:0]))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else        data <= row_bits;
    end
endmodule

// File: rtl/digit_overlay_osd.sv
// Overlays the recognition bounding box and a 2x-scaled glyph of the
// frame-stabilised digit onto the video stream, with a fixed 2-cycle latency.
module digit_overlay_osd
    import osd_pkg::*;
#(
    parameter int          STABLE_FRAMES = 3,
    parameter int          LINE_W        = 2,
    parameter logic [23:0] BOX_COLOR     = DEF_BOX_COLOR,
    parameter logic [23:0] GLYPH_COLOR   = DEF_GLYPH_COLOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    input  logic [10:0] x_min,
    input  logic [10:0] x_max,
    input  logic [10:0] y_min,
    input  logic [10:0] y_max,
    input  logic        box_valid,
    input  logic [7:0]  number_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic [7:0]  number_o,
    output logic        number_valid
);
    localparam logic [3:0]  STABLE_CNT = 4'(STABLE_FRAMES);
    localparam logic [11:0] LW         = 12'(LINE_W);
    localparam logic [11:0] GW_PIX     = 12'(GLYPH_W * GLYPH_SCALE);
    localparam logic [11:0] GH_PIX     = 12'(GLYPH_H * GLYPH_SCALE);
    localparam int          SCALE_SH   = $clog2(GLYPH_SCALE);

    logic       vsync_d, frame_start;
    box_t       box_in, box_q, box_cur;
    logic [7:0] cand_q;
    logic [3:0] count_q, count_next;
    coord_t     px_q, py_q, py_cur;

    assign frame_start = vsync_i & ~vsync_d;
    assign box_in      = {x_min, x_max, y_min, y_max, box_valid};
    // A pixel coinciding with the frame-start edge already sees the new frame.
    assign box_cur     = frame_start ? box_in : box_q;
    assign py_cur      = frame_start ? '0 : py_q;

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        count_next = 4'd1;
        if (number_i == cand_q)
            count_next = (count_q >= STABLE_CNT) ? STABLE_CNT : count_q + 4'd1;
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d      <= 1'b0;
            box_q        <= '0;
            cand_q       <= NO_DIGIT;
            count_q      <= '0;
            number_o     <= '0;
            number_valid <= 1'b0;
        end else begin
            vsync_d <= vsync_i;
            if (frame_start) begin
                box_q   <= box_in;
                cand_q  <= number_i;
                count_q <= count_next;
                if (count_next == STABLE_CNT) begin
                    if (number_i <= MAX_DIGIT) begin
                        number_o     <= number_i;
                        number_valid <= 1'b1;
                    end else begin
                        number_valid <= 1'b0;
                    end
                end
            end
        end
    end

    logic        hsync_1, vsync_1, de_1;
    logic [23:0] data_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= de_i ? sat_inc(px_q) : '0;
            if (frame_start)       py_q <= '0;
            else if (de_1 && !de_i) py_q <= sat_inc(py_q);
        end
    end

    // Stage 1: geometry on 12-bit values so the edge sums cannot wrap.
    logic [11:0] x_e, y_e, xmn_e, xmx_e, ymn_e, ymx_e, gy_e, dx, dy;
    logic        box_ok, in_box, on_edge, in_glyph;
    logic [6:0]  rom_addr;
    logic [2:0]  col;

    assign x_e   = {1'b0, px_q};
    assign y_e   = {1'b0, py_cur};
    assign xmn_e = {1'b0, box_cur.x_min};
    assign xmx_e = {1'b0, box_cur.x_max};
    assign ymn_e = {1'b0, box_cur.y_min};
    assign ymx_e = {1'b0, box_cur.y_max};

    assign box_ok  = box_cur.valid && (xmn_e <= xmx_e) && (ymn_e <= ymx_e);
    assign in_box  = (x_e >= xmn_e) && (x_e <= xmx_e) && (y_e >= ymn_e) && (y_e <= ymx_e);
    assign on_edge = (x_e < xmn_e + LW) || (x_e + LW > xmx_e) ||
                     (y_e < ymn_e + LW) || (y_e + LW > ymx_e);

    // The glyph sits above the box when there is room, otherwise just below it.
    assign gy_e     = (ymn_e >= 12'd16) ? ymn_e - 12'd16 : ymx_e + 12'd2;
    assign dx       = x_e - xmn_e;
    assign dy       = y_e - gy_e;
    assign in_glyph = (x_e >= xmn_e) && (dx < GW_PIX) && (y_e >= gy_e) && (dy < GH_PIX);
    assign col      = 3'(dx >> SCALE_SH);
    assign rom_addr = {number_o[3:0], 3'(dy >> SCALE_SH)};

    logic [GLYPH_W-1:0] rom_data, rom_shifted;
    logic               box_hit_1, glyph_en_1, glyph_px;
    logic [2:0]         col_1;

    digit_font_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_1    <= 1'b0;
            vsync_1    <= 1'b0;
            de_1       <= 1'b0;
            data_1     <= '0;
            box_hit_1  <= 1'b0;
            glyph_en_1 <= 1'b0;
            col_1      <= '0;
        end else begin
            hsync_1    <= hsync_i;
            vsync_1    <= vsync_i;
            de_1       <= de_i;
            data_1     <= data_i;
            box_hit_1  <= box_ok && in_box && on_edge;
            glyph_en_1 <= number_valid && box_ok && in_glyph;
            col_1      <= col;
        end
    end

    // Stage 2: shifting left by col brings font bit [4-col] to the MSB.
    assign rom_shifted = rom_data << col_1;
    assign glyph_px    = glyph_en_1 & rom_shifted[GLYPH_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            de_o    <= 1'b0;
            data_o  <= '0;
        end else begin
            hsync_o <= hsync_1;
            vsync_o <= vsync_1;
            de_o    <= de_1;
            if (de_1 && glyph_px)       data_o <= GLYPH_COLOR;
            else if (de_1 && box_hit_1) data_o <= BOX_COLOR;
            else                        data_o <= data_1;
        end
    end
endmodule
